// File: rtl/vdp_video_pkg.sv
// -----------------------------------------------------------------------------
// vdp_video_pkg
//   Shared definitions for the VDP video regenerator:
//   - default raster geometry (pixels per line, NTSC/PAL line counts)
//   - counter widths (11-bit signed pixel counter, 9-bit line counter)
//   - colour channel type rgb_t at the default channel width
//   - frame_lines(): selects the frame length for the next frame
// -----------------------------------------------------------------------------
package vdp_video_pkg;

    localparam int HCNT_W          = 11;
    localparam int VCNT_W          = 9;

    localparam int RGB_W_DEF       = 6;
    localparam int HWIDTH_DEF      = 342;
    localparam int NLINES_NTSC_DEF = 262;
    localparam int NLINES_PAL_DEF  = 313;

    typedef logic [RGB_W_DEF-1:0]     rgb_t;
    typedef logic signed [HCNT_W-1:0] hcnt_t;
    typedef logic [VCNT_W-1:0]        vcnt_t;

    // Frame length in lines for the requested standard.
    function automatic vcnt_t frame_lines(input logic pal,
                                          input int   lines_ntsc,
                                          input int   lines_pal);
        return pal ? vcnt_t'(lines_pal) : vcnt_t'(lines_ntsc);
    endfunction

endpackage

// File: rtl/vdp_frame_lock.sv
// -----------------------------------------------------------------------------
// vdp_frame_lock
//   Genlock tracker for the video regenerator. Watches the core vsync for a
//   falling edge (sampled on ena) and decides whether the local raster is
//   already aligned with it.
//
//   Ports:
//     clk, reset_n  clock, asynchronous active-low reset
//     ena           pixel-clock enable; the vsync history only advances on it
//     vs_n          core vsync (active low)
//     frame_top     local line counter is at line 0
//     frame_end     local raster is wrapping to line 0 on this cycle
//     resync        strobe: misaligned edge, reload the raster counters now
//     locked        registered lock status
// -----------------------------------------------------------------------------
module vdp_frame_lock
    import vdp_video_pkg::*;
#(
    parameter int LOCK_FRAMES = 3
)(
    input  logic clk,
    input  logic reset_n,
    input  logic ena,
    input  logic vs_n,
    input  logic frame_top,
    input  logic frame_end,
    output logic resync,
    output logic locked
);

    localparam int                CNT_W   = $clog2(LOCK_FRAMES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(LOCK_FRAMES);

    logic             vs_prev;
    logic             fall;
    logic             aligned;
    logic [CNT_W-1:0] lock_cnt;
    logic [CNT_W-1:0] cnt_nx;

    assign fall    = ena && vs_prev && !vs_n;
    // An edge landing on the natural wrap is as good as one at line 0.
    assign aligned = frame_top || frame_end;
    assign resync  = fall && !aligned;

    always_comb begin
        cnt_nx = lock_cnt;
        if (lock_cnt != CNT_MAX) begin
            cnt_nx = lock_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_prev  <= 1'b1;
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else begin
            if (ena) begin
                vs_prev <= vs_n;
            end
            if (fall) begin
                if (aligned) begin
                    lock_cnt <= cnt_nx;
                    locked   <= (cnt_nx == CNT_MAX);
                end else begin
                    lock_cnt <= '0;
                    locked   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/vdp_video_regen.sv
// -----------------------------------------------------------------------------
// vdp_video_regen
//   Regenerates clean HS/VS/DE and gated RGB from the VDP core pixel output.
//   Runs its own pixel/line counters (PAL or NTSC geometry, selected per
//   frame), genlocks them to the core vsync, and can pass the core signals
//   through untouched.
//
//   Ports:
//     clk, reset_n               clock, asynchronous active-low reset
//     ena                        10.7 MHz enable; CLK_DIV enables per pixel
//     pal_i                      1 = PAL line count, 0 = NTSC (frame boundary)
//     h_shift_i                  signed hcnt value loaded on resync
//     raw_i                      1 = mirror core sync/colour, de_o forced 1
//     vdp_hs_n_i, vdp_vs_n_i     core syncs
//     vdp_r_i/g_i/b_i            core colour
//     hs_n_o, vs_n_o, de_o       regenerated syncs and visible-area flag
//     r_o, g_o, b_o              gated colour
//     hcnt_o, vcnt_o             raster counters (hcnt signed)
//     locked_o                   genlock status
//
//   Build option: define VDP_SCANLINE_EN to halve the colour on odd lines
//   (not applied in raw mode).
// -----------------------------------------------------------------------------
module vdp_video_regen
    import vdp_video_pkg::*;
#(
    parameter int RGB_W       = RGB_W_DEF,
    parameter int HWIDTH      = HWIDTH_DEF,
    parameter int NLINES_NTSC = NLINES_NTSC_DEF,
    parameter int NLINES_PAL  = NLINES_PAL_DEF,
    parameter int CLK_DIV     = 2,
    parameter int HS_LEN      = 20,
    parameter int VS_LEN      = 4,
    parameter int BLANK_TOP   = 8,
    parameter int BLANK_L     = 60,
    parameter int BLANK_R     = 340,
    parameter int LOCK_FRAMES = 3
)(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     ena,
    input  logic                     pal_i,
    input  logic signed [HCNT_W-1:0] h_shift_i,
    input  logic                     raw_i,
    input  logic                     vdp_hs_n_i,
    input  logic                     vdp_vs_n_i,
    input  logic [RGB_W-1:0]         vdp_r_i,
    input  logic [RGB_W-1:0]         vdp_g_i,
    input  logic [RGB_W-1:0]         vdp_b_i,
    output logic                     hs_n_o,
    output logic                     vs_n_o,
    output logic                     de_o,
    output logic [RGB_W-1:0]         r_o,
    output logic [RGB_W-1:0]         g_o,
    output logic [RGB_W-1:0]         b_o,
    output logic signed [HCNT_W-1:0] hcnt_o,
    output logic [VCNT_W-1:0]        vcnt_o,
    output logic                     locked_o
);

    localparam hcnt_t      H_LAST     = hcnt_t'(HWIDTH - 1);
    localparam hcnt_t      H_SYNC_END = hcnt_t'(HS_LEN);
    localparam hcnt_t      H_VIS_L    = hcnt_t'(BLANK_L);
    localparam hcnt_t      H_VIS_R    = hcnt_t'(BLANK_R);
    localparam vcnt_t      V_SYNC_END = vcnt_t'(VS_LEN);
    localparam vcnt_t      V_VIS_T    = vcnt_t'(BLANK_TOP);
    localparam logic [1:0] DIV_LAST   = 2'(CLK_DIV - 1);

    logic [1:0] div;
    hcnt_t      hcnt;
    vcnt_t      vcnt;
    vcnt_t      nlines;

    logic tick;
    logic line_end;
    logic frame_end;
    logic resync;

    assign tick      = ena && (div == DIV_LAST);
    assign line_end  = tick && (hcnt == H_LAST);
    assign frame_end = line_end && (vcnt == (nlines - vcnt_t'(1)));

    // -------------------------------------------------------------------------
    // Genlock
    // -------------------------------------------------------------------------
    vdp_frame_lock #(
        .LOCK_FRAMES (LOCK_FRAMES)
    ) u_lock (
        .clk       (clk),
        .reset_n   (reset_n),
        .ena       (ena),
        .vs_n      (vdp_vs_n_i),
        .frame_top (vcnt == '0),
        .frame_end (frame_end),
        .resync    (resync),
        .locked    (locked_o)
    );

    // -------------------------------------------------------------------------
    // Raster counters. A resync wins over the normal advance; it only ever
    // fires on an enabled cycle, so the divider restarts cleanly.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div    <= '0;
            hcnt   <= '0;
            vcnt   <= '0;
            nlines <= vcnt_t'(NLINES_NTSC);
        end else if (resync) begin
            div  <= '0;
            hcnt <= h_shift_i;
            vcnt <= '0;
        end else if (ena) begin
            div <= tick ? 2'd0 : div + 2'd1;
            if (tick) begin
                if (hcnt == H_LAST) begin
                    hcnt <= '0;
                    if (frame_end) begin
                        vcnt   <= '0;
                        // PAL/NTSC changes are only picked up here.
                        nlines <= frame_lines(pal_i, NLINES_NTSC, NLINES_PAL);
                    end else begin
                        vcnt <= vcnt + vcnt_t'(1);
                    end
                end else begin
                    hcnt <= hcnt + hcnt_t'(1);
                end
            end
        end
    end

    assign hcnt_o = hcnt;
    assign vcnt_o = vcnt;

    // -------------------------------------------------------------------------
    // Decode. hcnt is signed, so the negative shift window falls outside both
    // the sync pulse and the visible area.
    // -------------------------------------------------------------------------
    logic hs_act;
    logic vs_act;
    logic vis;

    assign hs_act = (hcnt >= hcnt_t'(0)) && (hcnt < H_SYNC_END);
    assign vs_act = (vcnt < V_SYNC_END);
    assign vis    = (vcnt >= V_VIS_T) && (hcnt >= H_VIS_L) && (hcnt <= H_VIS_R);

    logic [RGB_W-1:0] r_g;
    logic [RGB_W-1:0] g_g;
    logic [RGB_W-1:0] b_g;

    always_comb begin
        r_g = vis ? vdp_r_i : '0;
        g_g = vis ? vdp_g_i : '0;
        b_g = vis ? vdp_b_i : '0;
`ifdef VDP_SCANLINE_EN
        if (vcnt[0]) begin
            r_g = r_g >> 1;
            g_g = g_g >> 1;
            b_g = b_g >> 1;
        end
`endif
    end

    // -------------------------------------------------------------------------
    // Output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_n_o <= 1'b1;
            vs_n_o <= 1'b1;
            de_o   <= 1'b0;
            r_o    <= '0;
            g_o    <= '0;
            b_o    <= '0;
        end else if (raw_i) begin
            hs_n_o <= vdp_hs_n_i;
            vs_n_o <= vdp_vs_n_i;
            de_o   <= 1'b1;
            r_o    <= vdp_r_i;
            g_o    <= vdp_g_i;
            b_o    <= vdp_b_i;
        end else begin
            hs_n_o <= !hs_act;
            vs_n_o <= !vs_act;
            de_o   <= vis;
            r_o    <= r_g;
            g_o    <= g_g;
            b_o    <= b_g;
        end
    end

endmodule
